// File: rtl/hazard_control_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Holds the forward-select encodings, the scoreboard slot payload, the
// hard-wired zero register specifier, widths and a select-priority helper.
package hazard_control_pkg;

   localparam int unsigned REG_W = 5;
   localparam int unsigned FWD_W = 2;
   localparam int unsigned CNT_W = 16;
   localparam int unsigned SLOTS = 3;

   // Slot indices: age order, youngest first.
   localparam int unsigned SLOT_EX  = 0;
   localparam int unsigned SLOT_MEM = 1;
   localparam int unsigned SLOT_WB  = 2;

   // EX operand source encodings.
   localparam logic [FWD_W-1:0] FWD_RF    = 2'b00;
   localparam logic [FWD_W-1:0] FWD_EXMEM = 2'b01;
   localparam logic [FWD_W-1:0] FWD_MEMWB = 2'b10;

   localparam logic [REG_W-1:0] REG_ZERO = '0;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   // Destination bookkeeping for one in-flight instruction.
   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
      logic             reg_wr;
      logic             is_load;
   } slot_t;

   // Newest producer wins: EX slot result sits in EX/MEM next cycle.
   function automatic logic [FWD_W-1:0] fwd_pick(input logic ex_hit,
                                                 input logic mem_hit);
      logic [FWD_W-1:0] sel;
      sel = FWD_RF;
      if (ex_hit)
         sel = FWD_EXMEM;
      else if (mem_hit)
         sel = FWD_MEMWB;
      return sel;
   endfunction

endpackage

// File: rtl/hazard_slot_match.sv
// Compares one scoreboard slot against one source register specifier.
// Ports:
//   slot_valid, slot_reg_wr  in   slot holds a live instruction that writes rd
//   slot_rd                  in   slot destination register
//   src                      in   source register being read
//   hit_c                    out  combinational match; r0 never matches
module hazard_slot_match
   import hazard_control_pkg::*;
(
   input  logic             slot_valid,
   input  logic             slot_reg_wr,
   input  logic [REG_W-1:0] slot_rd,
   input  logic [REG_W-1:0] src,
   output logic             hit_c
);

   assign hit_c = slot_valid & slot_reg_wr & (slot_rd == src) & (src != REG_ZERO);

endmodule

// File: rtl/hazard_control.sv
// Hazard detection and forwarding control for a five-stage in-order pipe.
// Tracks destinations of the instructions in EX, MEM and WB and decides
// stalls, bubbles, flushes and operand forwarding for the ID instruction.
// Build option: HAZARD_FORWARD_EN enables forwarding; without it every
// RAW dependency on EX or MEM is resolved by stalling.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   id_*                           ID-stage instruction attributes
//   ex_redirect                    taken branch/jump resolved in EX
//   mem_wait                       data memory busy, whole pipe freezes
//   stall_if_id, bubble_ex,
//   flush_if_id, freeze, fwd_id_a  combinational pipeline controls
//   fwd_a_sel, fwd_b_sel           registered EX operand selects
//   stall_cnt                      saturating count of bubble cycles
module hazard_control
   import hazard_control_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic             id_reg_wr,
   input  logic             id_is_load,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic [REG_W-1:0] id_rd,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic             id_br_rs1,
   input  logic             ex_redirect,
   input  logic             mem_wait,
   output logic             stall_if_id,
   output logic             bubble_ex,
   output logic             flush_if_id,
   output logic             freeze,
   output logic [FWD_W-1:0] fwd_a_sel,
   output logic [FWD_W-1:0] fwd_b_sel,
   output logic             fwd_id_a,
   output logic [CNT_W-1:0] stall_cnt
);

   slot_t slot_q [0:SLOTS-1];
   slot_t ex_next;

   logic ex_rs1_hit, ex_rs2_hit, mem_rs1_hit, mem_rs2_hit;
   logic hazard;

   // WB slot is never compared: the register file is write-first.
   hazard_slot_match u_ex_rs1 (
      .slot_valid  (slot_q[SLOT_EX].valid),
      .slot_reg_wr (slot_q[SLOT_EX].reg_wr),
      .slot_rd     (slot_q[SLOT_EX].rd),
      .src         (id_rs1),
      .hit_c       (ex_rs1_hit)
   );

   hazard_slot_match u_ex_rs2 (
      .slot_valid  (slot_q[SLOT_EX].valid),
      .slot_reg_wr (slot_q[SLOT_EX].reg_wr),
      .slot_rd     (slot_q[SLOT_EX].rd),
      .src         (id_rs2),
      .hit_c       (ex_rs2_hit)
   );

   hazard_slot_match u_mem_rs1 (
      .slot_valid  (slot_q[SLOT_MEM].valid),
      .slot_reg_wr (slot_q[SLOT_MEM].reg_wr),
      .slot_rd     (slot_q[SLOT_MEM].rd),
      .src         (id_rs1),
      .hit_c       (mem_rs1_hit)
   );

   hazard_slot_match u_mem_rs2 (
      .slot_valid  (slot_q[SLOT_MEM].valid),
      .slot_reg_wr (slot_q[SLOT_MEM].reg_wr),
      .slot_rd     (slot_q[SLOT_MEM].rd),
      .src         (id_rs2),
      .hit_c       (mem_rs2_hit)
   );

`ifdef HAZARD_FORWARD_EN
   logic load_use;
   logic br_hazard;

   // Only a load in EX, or a branch needing rs1 in ID before it can be
   // forwarded, costs a bubble.
   always_comb begin
      load_use  = slot_q[SLOT_EX].is_load &
                  ((ex_rs1_hit & (id_use_rs1 | id_br_rs1)) | (ex_rs2_hit & id_use_rs2));
      br_hazard = id_br_rs1 & (ex_rs1_hit | (mem_rs1_hit & slot_q[SLOT_MEM].is_load));
      hazard    = id_valid & (load_use | br_hazard);
   end

   // ALU result sitting in EX/MEM feeds the ID branch comparator directly.
   assign fwd_id_a = id_valid & id_br_rs1 & mem_rs1_hit & ~slot_q[SLOT_MEM].is_load
                   & ~ex_rs1_hit;

   // Selects travel with the instruction into EX; a bubble carries FWD_RF.
   always_ff @(posedge clk) begin
      if (reset) begin
         fwd_a_sel <= FWD_RF;
         fwd_b_sel <= FWD_RF;
      end else if (!mem_wait) begin
         if (bubble_ex) begin
            fwd_a_sel <= FWD_RF;
            fwd_b_sel <= FWD_RF;
         end else begin
            fwd_a_sel <= fwd_pick(id_valid & id_use_rs1 & ex_rs1_hit,
                                  id_valid & id_use_rs1 & mem_rs1_hit);
            fwd_b_sel <= fwd_pick(id_valid & id_use_rs2 & ex_rs2_hit,
                                  id_valid & id_use_rs2 & mem_rs2_hit);
         end
      end
   end
`else
   // Without forwarding any live producer in EX or MEM must drain to WB.
   always_comb begin
      hazard = id_valid &
               (((ex_rs1_hit | mem_rs1_hit) & (id_use_rs1 | id_br_rs1)) |
                ((ex_rs2_hit | mem_rs2_hit) & id_use_rs2));
   end

   assign fwd_id_a  = 1'b0;
   assign fwd_a_sel = FWD_RF;
   assign fwd_b_sel = FWD_RF;
`endif

   // Pipeline control: freeze overrides redirect, redirect overrides hazards.
   always_comb begin
      stall_if_id = 1'b0;
      bubble_ex   = 1'b0;
      flush_if_id = 1'b0;
      freeze      = mem_wait;
      if (mem_wait) begin
         stall_if_id = 1'b1;
      end else if (ex_redirect) begin
         bubble_ex   = 1'b1;
         flush_if_id = 1'b1;
      end else begin
         stall_if_id = hazard;
         bubble_ex   = hazard;
      end
   end

   // Payload the ID instruction carries into the EX slot.
   always_comb begin
      ex_next = '0;
      if (!bubble_ex) begin
         ex_next.valid   = id_valid;
         ex_next.rd      = id_rd;
         ex_next.reg_wr  = id_reg_wr;
         ex_next.is_load = id_is_load;
      end
   end

   // Scoreboard advance and bubble counter; both hold while frozen.
   always_ff @(posedge clk) begin
      if (reset) begin
         slot_q[SLOT_EX]  <= '0;
         slot_q[SLOT_MEM] <= '0;
         slot_q[SLOT_WB]  <= '0;
         stall_cnt        <= '0;
      end else if (!mem_wait) begin
         slot_q[SLOT_EX]  <= ex_next;
         slot_q[SLOT_MEM] <= slot_q[SLOT_EX];
         slot_q[SLOT_WB]  <= slot_q[SLOT_MEM];
         if (bubble_ex && (stall_cnt != CNT_MAX))
            stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule
